multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore FSM control unit for a multi-cycle MIPS-style datapath.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  output logic        IorD,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        Sign,
  output logic [1:0]  RegDst,
  output logic [1:0]  DatatoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out
);
  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MEM_ADR = 5'd2, S_MEM_RD = 5'd3, S_LW_WB = 5'd4,
    S_MEM_WR = 5'd5, S_R_EX = 5'd6, S_R_WB = 5'd7, S_BEQ = 5'd8, S_J = 5'd9,
    S_I_EX = 5'd10, S_I_WB = 5'd11, S_LUI = 5'd12, S_JAL = 5'd13, S_BNE = 5'd14
  } state_t;
  state_t state, next;
  logic ovf_q, r_ok, i_sign, arith;
  logic [2:0] r_alu, i_alu;
  logic [5:0] op, funct;
  logic unused_ok;
  assign op = Inst_in[31:26];
  assign funct = Inst_in[5:0];
  assign unused_ok = ^{zero, Inst_in[25:6]};
  assign state_out = state;
  always_comb begin
    r_ok = 1'b1;
    r_alu = 3'b010;
    case (funct)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b100110: r_alu = 3'b011;
      6'b100111: r_alu = 3'b100;
      6'b101010: r_alu = 3'b111;
      default:   r_ok = 1'b0;
    endcase
  end
  assign i_alu = op == 6'b001010 ? 3'b111 :
                 op == 6'b001100 ? 3'b000 :
                 op == 6'b001101 ? 3'b001 :
                 op == 6'b001110 ? 3'b011 : 3'b010;
  assign i_sign = op == 6'b001000 || op == 6'b001010;
  // only signed add/sub forms can trap; the flag suppresses the writeback
  assign arith = state == S_R_EX ? (funct == 6'b100000 || funct == 6'b100010) : op == 6'b001000;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
      ovf_q <= 1'b0;
    end else begin
      state <= next;
      if (state == S_R_EX || state == S_I_EX) ovf_q <= overflow & arith;
    end
  end
  always_comb begin
    next = S_IF;
    case (state)
      S_IF:      next = MIO_ready ? S_ID : S_IF;
      S_ID:
        case (op)
          6'b000000: next = r_ok ? S_R_EX : S_IF;
          6'b100011, 6'b101011: next = S_MEM_ADR;
          6'b000100: next = S_BEQ;
          6'b000101: next = S_BNE;
          6'b000010: next = S_J;
          6'b000011: next = S_JAL;
          6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: next = S_I_EX;
          6'b001111: next = S_LUI;
          default:   next = S_IF;
        endcase
      S_MEM_ADR: next = op == 6'b101011 ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  next = MIO_ready ? S_LW_WB : S_MEM_RD;
      S_MEM_WR:  next = MIO_ready ? S_IF : S_MEM_WR;
      S_R_EX:    next = S_R_WB;
      S_I_EX:    next = S_I_WB;
      default:   next = S_IF;
    endcase
  end
  always_comb begin
    IorD = 1'b0;
    IRWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    Branch = 1'b0;
    Sign = 1'b0;
    RegDst = 2'b00;
    DatatoReg = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    ALU_operation = 3'b000;
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = MIO_ready;
        ALUSrcB = 2'b01;
        ALU_operation = 3'b010;
        PCWrite = 1'b1;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        Sign = 1'b1;
        ALU_operation = 3'b010;
      end
      S_MEM_ADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        Sign = 1'b1;
        ALU_operation = 3'b010;
      end
      S_MEM_RD: begin
        IorD = 1'b1;
        MemRead = 1'b1;
      end
      S_LW_WB: begin
        DatatoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EX: begin
        ALUSrcA = 2'b01;
        ALU_operation = r_alu;
      end
      S_R_WB: begin
        RegDst = 2'b01;
        RegWrite = ~ovf_q;
      end
      S_I_EX: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        Sign = i_sign;
        ALU_operation = i_alu;
      end
      S_I_WB:    RegWrite = ~ovf_q;
      S_BEQ, S_BNE: begin
        ALUSrcA = 2'b01;
        ALU_operation = 3'b110;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        Branch = state == S_BEQ;
      end
      S_J: begin
        PCSource = 2'b10;
        PCWrite = 1'b1;
      end
      S_JAL: begin
        PCSource = 2'b10;
        PCWrite = 1'b1;
        RegDst = 2'b10;
        DatatoReg = 2'b11;
        RegWrite = 1'b1;
      end
      S_LUI: begin
        DatatoReg = 2'b10;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed instruction sequences with a queued expected-output scoreboard.
module tb_multi_cycle_ctrl;
  logic clk, reset, MIO_ready, zero, overflow;
  logic [31:0] Inst_in;
  logic IorD, IRWrite, MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond, Branch, Sign;
  logic [1:0] RegDst, DatatoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALU_operation;
  logic [4:0] state_out;
  typedef struct {
    string name;
    logic [26:0] v;
  } exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0;
  string cur = "reset";
  logic [26:0] got;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst_in(Inst_in), .zero(zero),
    .overflow(overflow), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .Sign(Sign), .RegDst(RegDst), .DatatoReg(DatatoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {state_out, IorD, IRWrite, MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond,
                Branch, Sign, RegDst, DatatoReg, ALUSrcA, ALUSrcB, PCSource, ALU_operation};

  function automatic logic [21:0] w(input int iord, irw, mr, mw, rw, pcw, pcwc, br, sg,
                                    input int rd, dr, sa, sb, ps, alu);
    return {1'(iord), 1'(irw), 1'(mr), 1'(mw), 1'(rw), 1'(pcw), 1'(pcwc), 1'(br), 1'(sg),
            2'(rd), 2'(dr), 2'(sa), 2'(sb), 2'(ps), 3'(alu)};
  endfunction

  function automatic logic [21:0] f_if(input int irw);
    return w(0, irw, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2);
  endfunction
  function automatic logic [21:0] f_id();
    return w(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 2);
  endfunction

  task automatic step(input logic rs, mio, input logic [31:0] ins, input logic z, ov,
                      input int es, input logic [21:0] ew);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs;
    MIO_ready = mio;
    Inst_in = ins;
    zero = z;
    overflow = ov;
    e.name = cur;
    e.v = {5'(es), ew};
    sbq.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ins);
    step(0, 1, ins, 0, 0, 0, f_if(1));
    step(0, 1, ins, 0, 0, 1, f_id());
  endtask

  task automatic r_op(input string nm, input logic [31:0] ins, input int alu, input logic ov, input int rw);
    cur = nm;
    fetch(ins);
    step(0, 1, ins, 0, ov, 6, w(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, alu));
    step(0, 1, ins, 0, 0, 7, w(0, 0, 0, 0, rw, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic i_op(input string nm, input logic [31:0] ins, input int alu, sg, input logic ov, input int rw);
    cur = nm;
    fetch(ins);
    step(0, 1, ins, 0, ov, 10, w(0, 0, 0, 0, 0, 0, 0, 0, sg, 0, 0, 1, 2, 0, alu));
    step(0, 1, ins, 0, 0, 11, w(0, 0, 0, 0, rw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: state/outputs got=%h expected=%h", e.name, got, e.v);
      end
    end
  end

  initial begin
    reset = 1'b1;
    MIO_ready = 1'b0;
    Inst_in = 32'h0;
    zero = 1'b0;
    overflow = 1'b0;
    repeat (2) @(posedge clk);
    step(1, 1, 32'h0, 0, 0, 0, f_if(1));
    step(0, 0, 32'h0, 0, 0, 0, f_if(0));
    r_op("add", 32'h00221820, 2, 0, 1);
    cur = "lw";
    fetch(32'h8C220004);
    step(0, 1, 32'h8C220004, 0, 0, 2, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 2));
    step(0, 0, 32'h8C220004, 0, 0, 3, w(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 32'h8C220004, 0, 0, 3, w(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 32'h8C220004, 0, 0, 3, w(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 32'h8C220004, 0, 0, 4, w(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    cur = "beq";
    step(0, 0, 32'h10220003, 1, 0, 0, f_if(0));
    fetch(32'h10220003);
    step(0, 1, 32'h10220003, 1, 0, 8, w(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 6));
    cur = "bne";
    fetch(32'h14220003);
    step(0, 1, 32'h14220003, 1, 0, 14, w(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 6));
    i_op("addi_ovf", 32'h20220005, 2, 1, 1, 0);
    i_op("addi", 32'h20220005, 2, 1, 0, 1);
    i_op("slti_ovf_ignored", 32'h28220005, 7, 1, 1, 1);
    i_op("andi", 32'h30220005, 0, 0, 0, 1);
    i_op("ori", 32'h34220005, 1, 0, 0, 1);
    i_op("xori", 32'h38220005, 3, 0, 0, 1);
    r_op("sub_ovf", 32'h00221822, 6, 1, 0);
    r_op("and", 32'h00221824, 0, 0, 1);
    r_op("or_ovf_ignored", 32'h00221825, 1, 1, 1);
    r_op("xor", 32'h00221826, 3, 0, 1);
    r_op("nor", 32'h00221827, 4, 0, 1);
    r_op("slt", 32'h0022182A, 7, 0, 1);
    cur = "bad_op";
    fetch(32'hFC000000);
    cur = "bad_funct";
    fetch(32'h00221821);
    cur = "j";
    fetch(32'h08000010);
    step(0, 1, 32'h08000010, 0, 0, 9, w(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    cur = "jal";
    fetch(32'h0C000010);
    step(0, 1, 32'h0C000010, 0, 0, 13, w(0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 3, 0, 0, 2, 0));
    cur = "lui";
    fetch(32'h3C011234);
    step(0, 1, 32'h3C011234, 0, 0, 12, w(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    cur = "sw_reset";
    fetch(32'hAC220004);
    step(0, 1, 32'hAC220004, 0, 0, 2, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 2));
    step(0, 0, 32'hAC220004, 0, 0, 5, w(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 32'hAC220004, 0, 0, 5, w(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 32'hAC220004, 0, 0, 0, f_if(0));
    cur = "sw";
    fetch(32'hAC220004);
    step(0, 1, 32'hAC220004, 0, 0, 2, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 2));
    step(0, 1, 32'hAC220004, 0, 0, 5, w(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cur = "after_sw";
    step(0, 1, 32'h0, 0, 0, 0, f_if(1));
    repeat (4) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
